mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 200 ++++++++++++++++++++
 tb/tb_mem_stage.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage sitting between EX/MEM and MEM/WB.
// Non-memory instructions pass straight through. LOAD/STORE stall the front
// of the pipeline, issue one data-memory request, wait for MemAck, then
// release the instruction with its load data on the following cycle.
//
// Optional feature: define MEM_TIMEOUT_EN to abort an access that has not
// been acknowledged within MEM_TIMEOUT ACCESS cycles (data 32'hDEADBEEF,
// sticky MemError). Without it, ACCESS waits indefinitely.
//
// Ports
//   clock, reset            stage clock, asynchronous active-high reset
//   FromEX_*                EX/MEM register contents (InstType 2 = LOAD, 3 = STORE)
//   ToMEMWB_*               MEM/WB register feed (bubble = all zero while stalled)
//   Stall                   freezes PC, IF/ID, ID/EX, EX/MEM
//   MemReq, MemWrite        registered request and write strobe
//   MemAddr, MemWData       registered word address and store data
//   MemRData, MemAck        read data and one-cycle completion pulse
//   MemError                sticky timeout flag (0 when MEM_TIMEOUT_EN undefined)
module mem_stage #(
    parameter int unsigned MEM_TIMEOUT = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] FromEX_Inst,
    input  logic [31:0] FromEX_NewPC,
    input  logic [31:0] FromEX_RegDataA,
    input  logic [31:0] FromEX_RegDataB,
    input  logic [31:0] FromEX_Imm,
    input  logic [31:0] FromEX_ALUOutput,
    input  logic [3:0]  FromEX_InstNum,
    input  logic [3:0]  FromEX_InstType,
    output logic [31:0] ToMEMWB_Inst,
    output logic [31:0] ToMEMWB_NewPC,
    output logic [31:0] ToMEMWB_RegDataA,
    output logic [31:0] ToMEMWB_RegDataB,
    output logic [31:0] ToMEMWB_Imm,
    output logic [31:0] ToMEMWB_ALUOutput,
    output logic [31:0] ToMEMWB_MemData,
    output logic [3:0]  ToMEMWB_InstNum,
    output logic [3:0]  ToMEMWB_InstType,
    output logic        Stall,
    output logic        MemReq,
    output logic        MemWrite,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWData,
    input  logic [31:0] MemRData,
    input  logic        MemAck,
    output logic        MemError
);

    localparam int unsigned DW = 32;
    localparam int unsigned TW = 4;
    localparam logic [TW-1:0] TYPE_LOAD  = TW'(2);
    localparam logic [TW-1:0] TYPE_STORE = TW'(3);

    // Reject unusable timeout values at elaboration.
    if ((MEM_TIMEOUT < 2) || (MEM_TIMEOUT > 255)) begin : g_timeout_range
        $error("mem_stage: MEM_TIMEOUT must be in 2..255");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_write_q, mem_write_d;
    logic [DW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] data_q, data_d;
    logic          is_mem;
    logic          pass;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned   CW         = 8;
    localparam logic [CW-1:0] CNT_LAST   = CW'(MEM_TIMEOUT - 1);
    localparam logic [DW-1:0] ABORT_DATA = 32'hDEADBEEF;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
`endif

    assign is_mem = (FromEX_InstType == TYPE_LOAD) || (FromEX_InstType == TYPE_STORE);

    // State and request registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_write_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            data_q      <= '0;
`ifdef MEM_TIMEOUT_EN
            cnt_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_write_q <= mem_write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            data_q      <= data_d;
`ifdef MEM_TIMEOUT_EN
            cnt_q       <= cnt_d;
            err_q       <= err_d;
`endif
        end
    end

    // Next-state, request and stall/passthrough control.
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_write_d = mem_write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        data_d      = data_q;
`ifdef MEM_TIMEOUT_EN
        cnt_d       = cnt_q;
        err_d       = err_q;
`endif
        Stall       = 1'b0;
        pass        = 1'b0;

        case (state_q)
            IDLE: begin
                if (is_mem) begin
                    // Launch the access; address/data are latched so they stay
                    // stable for the whole ACCESS phase.
                    Stall       = 1'b1;
                    state_d     = ACCESS;
                    mem_req_d   = 1'b1;
                    mem_write_d = (FromEX_InstType == TYPE_STORE);
                    addr_d      = {FromEX_ALUOutput[31:2], 2'b00};
                    wdata_d     = FromEX_RegDataB;
`ifdef MEM_TIMEOUT_EN
                    cnt_d       = '0;
`endif
                end else begin
                    pass = 1'b1;
                end
            end
            ACCESS: begin
                Stall = 1'b1;
                if (MemAck) begin
                    // The latched write strobe tells load from store here.
                    data_d      = mem_write_q ? '0 : MemRData;
                    mem_req_d   = 1'b0;
                    mem_write_d = 1'b0;
                    state_d     = DONE;
                end
`ifdef MEM_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    data_d      = ABORT_DATA;
                    mem_req_d   = 1'b0;
                    mem_write_d = 1'b0;
                    err_d       = 1'b1;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
`endif
            end
            DONE: begin
                pass    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // MEM/WB feed: passthrough when not stalled, bubble otherwise.
    assign ToMEMWB_Inst      = pass ? FromEX_Inst      : '0;
    assign ToMEMWB_NewPC     = pass ? FromEX_NewPC     : '0;
    assign ToMEMWB_RegDataA  = pass ? FromEX_RegDataA  : '0;
    assign ToMEMWB_RegDataB  = pass ? FromEX_RegDataB  : '0;
    assign ToMEMWB_Imm       = pass ? FromEX_Imm       : '0;
    assign ToMEMWB_ALUOutput = pass ? FromEX_ALUOutput : '0;
    assign ToMEMWB_InstNum   = pass ? FromEX_InstNum   : '0;
    assign ToMEMWB_InstType  = pass ? FromEX_InstType  : '0;
    assign ToMEMWB_MemData   = (state_q == DONE) ? data_q : '0;

    assign MemReq   = mem_req_q;
    assign MemWrite = mem_write_q;
    assign MemAddr  = addr_q;
    assign MemWData = wdata_q;

`ifdef MEM_TIMEOUT_EN
    assign MemError = err_q;
`else
    assign MemError = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed and randomized checks of mem_stage against a
// transaction-level model of one memory instruction in flight.
module tb_mem_stage;

    localparam int unsigned TB_TIMEOUT = 8;
`ifdef MEM_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] FromEX_Inst, FromEX_NewPC, FromEX_RegDataA, FromEX_RegDataB;
    logic [31:0] FromEX_Imm, FromEX_ALUOutput;
    logic [3:0]  FromEX_InstNum, FromEX_InstType;
    logic [31:0] ToMEMWB_Inst, ToMEMWB_NewPC, ToMEMWB_RegDataA, ToMEMWB_RegDataB;
    logic [31:0] ToMEMWB_Imm, ToMEMWB_ALUOutput, ToMEMWB_MemData;
    logic [3:0]  ToMEMWB_InstNum, ToMEMWB_InstType;
    logic        Stall, MemReq, MemWrite, MemAck, MemError;
    logic [31:0] MemAddr, MemWData, MemRData;

    mem_stage #(.MEM_TIMEOUT(TB_TIMEOUT)) dut (
        .clock            (clock),
        .reset            (reset),
        .FromEX_Inst      (FromEX_Inst),
        .FromEX_NewPC     (FromEX_NewPC),
        .FromEX_RegDataA  (FromEX_RegDataA),
        .FromEX_RegDataB  (FromEX_RegDataB),
        .FromEX_Imm       (FromEX_Imm),
        .FromEX_ALUOutput (FromEX_ALUOutput),
        .FromEX_InstNum   (FromEX_InstNum),
        .FromEX_InstType  (FromEX_InstType),
        .ToMEMWB_Inst     (ToMEMWB_Inst),
        .ToMEMWB_NewPC    (ToMEMWB_NewPC),
        .ToMEMWB_RegDataA (ToMEMWB_RegDataA),
        .ToMEMWB_RegDataB (ToMEMWB_RegDataB),
        .ToMEMWB_Imm      (ToMEMWB_Imm),
        .ToMEMWB_ALUOutput(ToMEMWB_ALUOutput),
        .ToMEMWB_MemData  (ToMEMWB_MemData),
        .ToMEMWB_InstNum  (ToMEMWB_InstNum),
        .ToMEMWB_InstType (ToMEMWB_InstType),
        .Stall            (Stall),
        .MemReq           (MemReq),
        .MemWrite         (MemWrite),
        .MemAddr          (MemAddr),
        .MemWData         (MemWData),
        .MemRData         (MemRData),
        .MemAck           (MemAck),
        .MemError         (MemError)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model of the instruction currently owning the stage.
    bit          m_active;   // request outstanding
    bit          m_done;     // response in hand, release this cycle
    bit          m_err;
    bit          m_store;
    int unsigned m_wait;     // ACCESS cycles spent so far
    logic [31:0] m_addr, m_wdata, m_data;
    bit          adv = 1'b1; // EX/MEM loads a new instruction at the coming edge

    // Compare DUT outputs with the model, then advance the model across the next edge.
    task automatic model_cycle();
        bit          is_mem, e_stall, e_pass, e_req;
        logic [31:0] e_mdata;
        if (reset) begin
            m_active = 1'b0;
            m_done   = 1'b0;
            m_err    = 1'b0;
        end
        is_mem  = (FromEX_InstType == 4'd2) || (FromEX_InstType == 4'd3);
        e_req   = 1'b0;
        e_mdata = 32'h0;
        if (m_done) begin
            e_stall = 1'b0; e_pass = 1'b1; e_mdata = m_data;
        end else if (m_active) begin
            e_stall = 1'b1; e_pass = 1'b0; e_req = 1'b1;
        end else begin
            e_stall = is_mem; e_pass = !is_mem;
        end

        chk("Stall",    32'(Stall),    32'(e_stall));
        chk("MemReq",   32'(MemReq),   32'(e_req));
        chk("MemWrite", 32'(MemWrite), 32'(e_req && m_store));
        chk("MemError", 32'(MemError), 32'(m_err));
        chk("MemData",  ToMEMWB_MemData, e_mdata);
        chk("Inst",     ToMEMWB_Inst,      e_pass ? FromEX_Inst      : 32'h0);
        chk("NewPC",    ToMEMWB_NewPC,     e_pass ? FromEX_NewPC     : 32'h0);
        chk("RegDataA", ToMEMWB_RegDataA,  e_pass ? FromEX_RegDataA  : 32'h0);
        chk("RegDataB", ToMEMWB_RegDataB,  e_pass ? FromEX_RegDataB  : 32'h0);
        chk("Imm",      ToMEMWB_Imm,       e_pass ? FromEX_Imm       : 32'h0);
        chk("ALUOut",   ToMEMWB_ALUOutput, e_pass ? FromEX_ALUOutput : 32'h0);
        chk("InstNum",  32'(ToMEMWB_InstNum),  32'(e_pass ? FromEX_InstNum  : 4'd0));
        chk("InstType", 32'(ToMEMWB_InstType), 32'(e_pass ? FromEX_InstType : 4'd0));
        if (e_req) begin
            chk("MemAddr",  MemAddr,  m_addr);
            chk("MemWData", MemWData, m_wdata);
        end
        adv = !e_stall;

        if (!reset) begin
            if (m_done) begin
                m_done = 1'b0;
            end else if (m_active) begin
                m_wait++;
                if (MemAck) begin
                    m_data   = m_store ? 32'h0 : MemRData;
                    m_active = 1'b0;
                    m_done   = 1'b1;
                end else if (TO_EN && (m_wait == TB_TIMEOUT)) begin
                    m_data   = 32'hDEADBEEF;
                    m_err    = 1'b1;
                    m_active = 1'b0;
                    m_done   = 1'b1;
                end
            end else if (is_mem) begin
                m_active = 1'b1;
                m_wait   = 0;
                m_store  = (FromEX_InstType == 4'd3);
                m_addr   = {FromEX_ALUOutput[31:2], 2'b00};
                m_wdata  = FromEX_RegDataB;
            end
        end
    endtask

    task automatic mid_cycle();
        @(negedge clock);
        model_cycle();
    endtask

    task automatic to_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic present(input logic [3:0] typ, input logic [31:0] alu,
                           input logic [31:0] regb, input logic [3:0] num);
        FromEX_InstType  = typ;
        FromEX_ALUOutput = alu;
        FromEX_RegDataB  = regb;
        FromEX_InstNum   = num;
        FromEX_Inst      = $urandom;
        FromEX_NewPC     = $urandom;
        FromEX_RegDataA  = $urandom;
        FromEX_Imm       = $urandom;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int stall_n;
        int req_n;
        logic [3:0] typ;

        reset    = 1'b1;
        MemAck   = 1'b0;
        MemRData = 32'h0;
        present(4'd0, 32'h0, 32'h0, 4'd0);
        #1;
        chk("rst_async_req", 32'(MemReq),   32'd0);
        chk("rst_async_err", 32'(MemError), 32'd0);
        chk("rst_async_stall", 32'(Stall),  32'd0);
        mid_cycle(); to_edge();
        mid_cycle(); to_edge();
        reset = 1'b0;

        // Non-memory passthrough in the same cycle.
        present(4'd1, 32'h00000010, 32'h0, 4'd1);
        #1;
        chk("nm_alu",     ToMEMWB_ALUOutput, 32'h00000010);
        chk("nm_memdata", ToMEMWB_MemData,   32'h0);
        chk("nm_stall",   32'(Stall),  32'd0);
        chk("nm_req",     32'(MemReq), 32'd0);
        mid_cycle(); to_edge();

        // LOAD with ack in the first ACCESS cycle.
        present(4'd2, 32'h00000103, 32'h0, 4'd2);
        MemAck = 1'b0;
        stall_n = 0;
        mid_cycle(); stall_n += int'(Stall);
        chk("ld_issue_req", 32'(MemReq), 32'd0);
        to_edge();
        MemAck = 1'b1; MemRData = 32'hCAFEF00D;
        mid_cycle(); stall_n += int'(Stall);
        chk("ld_addr", MemAddr, 32'h00000100);
        chk("ld_req",  32'(MemReq), 32'd1);
        to_edge();
        MemAck = 1'b0; MemRData = $urandom;
        mid_cycle();
        chk("ld_data",    ToMEMWB_MemData, 32'hCAFEF00D);
        chk("ld_done_stall", 32'(Stall), 32'd0);
        chk("ld_stall_cycles", 32'(stall_n), 32'd2);
        chk("ld_instnum", 32'(ToMEMWB_InstNum), 32'd2);
        to_edge();
        present(4'd0, 32'h0, 32'h0, 4'd0);
        mid_cycle(); to_edge();

        // STORE with ack after 5 ACCESS cycles.
        present(4'd3, 32'h00000200, 32'h12345678, 4'd3);
        stall_n = 0;
        mid_cycle(); stall_n += int'(Stall);
        for (int i = 1; i <= 5; i++) begin
            to_edge();
            MemAck = (i == 5); MemRData = $urandom;
            mid_cycle(); stall_n += int'(Stall);
            chk("st_wdata", MemWData, 32'h12345678);
            chk("st_write", 32'(MemWrite), 32'd1);
        end
        to_edge();
        MemAck = 1'b0;
        mid_cycle();
        chk("st_memdata", ToMEMWB_MemData, 32'h0);
        chk("st_stall_cycles", 32'(stall_n), 32'd6);
        to_edge();
        present(4'd0, 32'h0, 32'h0, 4'd0);
        mid_cycle(); to_edge();

        // Back-to-back LOADs; stray acks in DONE and in the next issue cycle.
        req_n = 0;
        present(4'd2, 32'h00000040, 32'h0, 4'd5);
        mid_cycle(); req_n += int'(MemReq); to_edge();
        MemAck = 1'b1; MemRData = 32'h11110001;
        mid_cycle(); req_n += int'(MemReq); to_edge();
        MemAck = 1'b1; MemRData = 32'hBADBAD00;
        mid_cycle(); req_n += int'(MemReq);
        chk("b2b_data1", ToMEMWB_MemData, 32'h11110001);
        chk("b2b_num1",  32'(ToMEMWB_InstNum), 32'd5);
        to_edge();
        present(4'd2, 32'h00000044, 32'h0, 4'd6);
        mid_cycle(); req_n += int'(MemReq); to_edge();
        MemAck = 1'b1; MemRData = 32'h22220002;
        mid_cycle(); req_n += int'(MemReq); to_edge();
        MemAck = 1'b0;
        mid_cycle(); req_n += int'(MemReq);
        chk("b2b_data2", ToMEMWB_MemData, 32'h22220002);
        chk("b2b_num2",  32'(ToMEMWB_InstNum), 32'd6);
        chk("b2b_req_cycles", 32'(req_n), 32'd2);
        to_edge();
        present(4'd0, 32'h0, 32'h0, 4'd0);
        mid_cycle(); to_edge();

`ifdef MEM_TIMEOUT_EN
        // Unacknowledged access aborts after TB_TIMEOUT ACCESS cycles.
        present(4'd2, 32'h00000080, 32'h0, 4'd7);
        MemAck = 1'b0;
        mid_cycle(); to_edge();
        req_n = 0;
        for (int i = 0; i < int'(TB_TIMEOUT); i++) begin
            mid_cycle(); req_n += int'(MemReq); to_edge();
        end
        mid_cycle();
        chk("to_data",   ToMEMWB_MemData, 32'hDEADBEEF);
        chk("to_err",    32'(MemError), 32'd1);
        chk("to_cycles", 32'(req_n), 32'd8);
        to_edge();
        present(4'd0, 32'h0, 32'h0, 4'd0);
        for (int i = 0; i < 5; i++) begin
            mid_cycle(); to_edge();
        end
        chk("to_sticky", 32'(MemError), 32'd1);
`else
        // Without the timeout the stall persists until an ack arrives.
        present(4'd2, 32'h00000080, 32'h0, 4'd7);
        MemAck = 1'b0;
        mid_cycle(); to_edge();
        stall_n = 0;
        for (int i = 0; i < 105; i++) begin
            mid_cycle(); stall_n += int'(Stall); to_edge();
        end
        chk("hang_stall", 32'(stall_n), 32'd105);
        chk("hang_err",   32'(MemError), 32'd0);
        MemAck = 1'b1; MemRData = 32'h0BADF00D;
        mid_cycle(); to_edge();
        MemAck = 1'b0;
        mid_cycle();
        chk("hang_data", ToMEMWB_MemData, 32'h0BADF00D);
        to_edge();
        present(4'd0, 32'h0, 32'h0, 4'd0);
        mid_cycle(); to_edge();
`endif

        // Reset in the middle of ACCESS, then a stray ack after release.
        present(4'd2, 32'h00000300, 32'h0, 4'd8);
        MemAck = 1'b0;
        mid_cycle(); to_edge();
        mid_cycle();
        chk("rst_pre_req", 32'(MemReq), 32'd1);
        #2;
        reset = 1'b1;
        present(4'd1, 32'h00000055, 32'h0, 4'd9);
        #1;
        chk("rst_req_drop", 32'(MemReq), 32'd0);
        chk("rst_stall",    32'(Stall),  32'd0);
        chk("rst_err",      32'(MemError), 32'd0);
        to_edge();
        mid_cycle(); to_edge();
        reset = 1'b0;
        MemAck = 1'b1; MemRData = 32'hBAD0BAD0;
        mid_cycle();
        chk("rst_stray_req",  32'(MemReq), 32'd0);
        chk("rst_stray_data", ToMEMWB_MemData, 32'h0);
        chk("rst_stray_alu",  ToMEMWB_ALUOutput, 32'h00000055);
        to_edge();
        MemAck = 1'b0;
        mid_cycle(); to_edge();

        // Random traffic: new instruction only when the stage accepted the last one.
        for (int c = 0; c < 3000; c++) begin
            if (adv) begin
                case ($urandom_range(0, 3))
                    0:       typ = 4'd2;
                    1:       typ = 4'd3;
                    default: typ = 4'($urandom);
                endcase
                present(typ, $urandom, $urandom, 4'($urandom));
            end
            MemAck   = ($urandom_range(0, 9) < 3);
            MemRData = $urandom;
            mid_cycle(); to_edge();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
